// File: rtl/doorbell_array.sv
// doorbell_array: round-robin doorbell arbiter with REQ/SERVE handshake.
// Define DOORBELL_ARRAY_TIMEOUT_EN to abort over-long services and flag them in timeout_out.
module doorbell_array #(
   parameter int NUM_CH      = 4,
   parameter int TIMEOUT_CYC = 255,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] set_in,
   input  logic              done_in,
   output logic              req_valid_out,
   output logic [CH_W-1:0]   req_ch_out,
   input  logic              req_ready_in,
   output logic              active_out,
   output logic [NUM_CH-1:0] busy_out,
   output logic [NUM_CH-1:0] timeout_out,
   input  logic [NUM_CH-1:0] err_clr_in
);
   typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;
   state_t state;
   logic [NUM_CH-1:0] pending, ch_mask, pend_clr, rot;
   logic [2*NUM_CH-1:0] dbl;
   logic [CH_W-1:0] rr_ptr, sel, nxt_ptr;
   logic accept, tmo;
   int off;
   assign ch_mask  = NUM_CH'(1) << req_ch_out;
   assign accept   = (state == REQ) && req_ready_in;
   assign pend_clr = accept ? ch_mask : '0;
   assign busy_out = pending | (active_out ? ch_mask : '0);
   assign nxt_ptr  = (int'(req_ch_out) == NUM_CH - 1) ? '0 : req_ch_out + 1'b1;
   // Rotate pending so rr_ptr sits at bit 0, then the lowest set bit is the winner.
   always_comb begin
      dbl = {pending, pending} >> rr_ptr;
      rot = dbl[NUM_CH-1:0];
      off = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) if (rot[k]) off = k;
      off = off + int'(rr_ptr);
      sel = CH_W'((off >= NUM_CH) ? off - NUM_CH : off);
   end
`ifdef DOORBELL_ARRAY_TIMEOUT_EN
   logic [CNT_W-1:0] cnt;
   assign tmo = (state == SERVE) && !done_in && (cnt == CNT_W'(TIMEOUT_CYC - 1));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         timeout_out <= '0;
      end else begin
         cnt         <= accept ? '0 : (state == SERVE) ? cnt + 1'b1 : cnt;
         timeout_out <= (timeout_out & ~err_clr_in) | (tmo ? ch_mask : '0);
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg  = ^{err_clr_in, CNT_W'(TIMEOUT_CYC)};
   assign tmo         = 1'b0;
   assign timeout_out = '0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~pend_clr) | set_in;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         req_ch_out    <= '0;
         req_valid_out <= 1'b0;
         active_out    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|pending) begin
               req_ch_out    <= sel;
               req_valid_out <= 1'b1;
               state         <= REQ;
            end
            REQ: if (req_ready_in) begin
               req_valid_out <= 1'b0;
               active_out    <= 1'b1;
               state         <= SERVE;
            end
            SERVE: if (done_in || tmo) begin
               active_out <= 1'b0;
               rr_ptr     <= nxt_ptr;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_doorbell_array.sv
// tb_doorbell_array: randomized and directed checks of doorbell_array against a behavioural model.
// Follows DOORBELL_ARRAY_TIMEOUT_EN so the model matches the build under test.
module tb_doorbell_array;
   localparam int NCH = 4;
   localparam int TMO = 8;
`ifdef DOORBELL_ARRAY_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [3:0] s_set = '0, s_clr = '0;
   logic s_done = 1'b0, s_ready = 1'b1;
   logic req_valid_out, active_out;
   logic [1:0] req_ch_out;
   logic [3:0] busy_out, timeout_out;
   int n_cmp = 0, n_err = 0;
   bit auto_done = 0;
   int q[$];
   int m_ch, m_ptr, m_cnt;
   bit m_req, m_srv;
   bit [3:0] m_pend, m_tmo;

   doorbell_array #(.NUM_CH(NCH), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .set_in(s_set), .done_in(s_done),
      .req_valid_out(req_valid_out), .req_ch_out(req_ch_out), .req_ready_in(s_ready),
      .active_out(active_out), .busy_out(busy_out), .timeout_out(timeout_out),
      .err_clr_in(s_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ch = 0; m_ptr = 0; m_cnt = 0; m_req = 0; m_srv = 0; m_pend = '0; m_tmo = '0;
   endtask

   // One clock edge of the doorbell rules, computed from the pre-edge picture.
   task automatic model_step(input logic [3:0] s, input logic d, input logic r, input logic [3:0] e);
      bit [3:0] np;
      int pick;
      pick = -1;
      if (!m_req && !m_srv)
         for (int k = 0; k < NCH; k++)
            if (m_pend[(m_ptr + k) % NCH]) begin
               pick = (m_ptr + k) % NCH;
               break;
            end
      np = m_pend;
      if (m_req && r) np[m_ch] = 1'b0;
      np |= s;
      m_tmo &= ~e;
      if (m_srv) begin
         if (d || (TMO_EN && m_cnt == TMO - 1)) begin
            if (!d) m_tmo[m_ch] = 1'b1;
            m_srv = 0;
            m_ptr = (m_ch + 1) % NCH;
         end else m_cnt++;
      end else if (m_req) begin
         if (r) begin
            m_req = 0; m_srv = 1; m_cnt = 0;
         end
      end else if (pick >= 0) begin
         m_ch = pick; m_req = 1;
      end
      m_pend = np;
   endtask

   task automatic cyc(input logic [3:0] s, input logic d, input logic r, input logic [3:0] e);
      s_set = s; s_ready = r; s_clr = e;
      s_done = auto_done ? active_out : d;
      if (req_valid_out && s_ready) q.push_back(int'(req_ch_out));
      @(posedge clk);
      model_step(s_set, s_done, s_ready, s_clr);
      @(negedge clk);
      check("req_valid", req_valid_out, m_req);
      check("req_ch", req_ch_out, m_ch);
      check("active", active_out, m_srv);
      check("busy", busy_out, m_pend | (m_srv ? 4'(1 << m_ch) : 4'd0));
      check("timeout", timeout_out, m_tmo);
   endtask

   task automatic do_reset();
      s_set = '0; s_done = 0; s_ready = 1; s_clr = '0;
      rst = 1'b1;
      #1;
      check("rst_valid", req_valid_out, 0);
      check("rst_ch", req_ch_out, 0);
      check("rst_active", active_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_timeout", timeout_out, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_active(input int ch);
      bit hit;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         cyc(4'd0, 1'b0, 1'b1, 4'd0);
         hit = active_out && int'(req_ch_out) == ch;
      end
      check("wait_active", hit, 1);
   endtask

   function automatic int order();
      int v;
      v = 0;
      foreach (q[i]) v = v * 16 + q[i] + 1;
      return v;
   endfunction

   initial begin
      int n2;
      model_reset();
      @(negedge clk);
      do_reset();
      // single ring on channel 1
      cyc(4'b0010, 0, 1, 0);
      check("single_busy", busy_out, 4'b0010);
      cyc(4'b0000, 0, 1, 0);
      check("single_req", {req_valid_out, req_ch_out}, 3'b101);
      cyc(4'b0000, 0, 1, 0);
      cyc(4'b0000, 1, 1, 0);
      check("single_done", busy_out, 0);
      // round robin from a fresh pointer
      do_reset();
      q.delete();
      auto_done = 1;
      cyc(4'b1111, 0, 1, 0);
      repeat (20) cyc(4'b0000, 0, 1, 0);
      check("rr_order_all", order(), 32'h1234);
      q.delete();
      cyc(4'b0011, 0, 1, 0);
      repeat (10) cyc(4'b0000, 0, 1, 0);
      check("rr_order_01", order(), 32'h12);
      auto_done = 0;
      // backpressure with coalescing sets, then a re-pend during service
      q.delete();
      cyc(4'b0100, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc((i % 2 == 0) ? 4'b0100 : 4'b0000, 0, 0, 0);
      check("bp_hold", {req_valid_out, active_out, req_ch_out}, 4'b1010);
      cyc(4'b0000, 0, 1, 0);
      cyc(4'b0100, 0, 1, 0);
      cyc(4'b0000, 1, 1, 0);
      check("repend_busy", busy_out, 4'b0100);
      auto_done = 1;
      repeat (8) cyc(4'b0000, 0, 1, 0);
      auto_done = 0;
      n2 = 0;
      foreach (q[i]) if (q[i] == 2) n2++;
      check("coalesce_cnt", n2, 2);
      // timeout, clear, and done landing on the last allowed cycle
      do_reset();
      cyc(4'b0011, 0, 1, 0);
      wait_active(0);
      repeat (8) cyc(4'b0000, 0, 1, 0);
      check("to_flag", timeout_out, TMO_EN ? 32'd1 : 32'd0);
      check("to_active", active_out, !TMO_EN);
      cyc(4'b0000, 0, 1, 4'b0001);
      check("to_clear", timeout_out, 0);
`ifndef DOORBELL_ARRAY_TIMEOUT_EN
      cyc(4'b0000, 1, 1, 0);
`endif
      wait_active(1);
      repeat (7) cyc(4'b0000, 0, 1, 0);
      cyc(4'b0000, 1, 1, 0);
      check("to_done_wins", timeout_out, 0);
      // reset while ch3 is in service and ch1 pending
      do_reset();
      cyc(4'b1000, 0, 1, 0);
      wait_active(3);
      cyc(4'b0010, 0, 1, 0);
      do_reset();
      repeat (6) cyc(4'b0000, 0, 1, 0);
      check("rst_no_dispatch", {req_valid_out, active_out, busy_out}, 0);
      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         else cyc(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/doorbell_array.md
DOORBELL_ARRAY -- requirements
Module: doorbell_array

Interface
REQ-001 Parameter NUM_CH, default 4, number of doorbell channels (2..32).
REQ-002 Parameter TIMEOUT_CYC, default 255, max SERVE cycles before abort (1..65535); CH_W = max(1,$clog2(NUM_CH)), CNT_W = $clog2(TIMEOUT_CYC+1).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 set_in  input  NUM_CH  per-channel ring, one-cycle pulse or level, sampled each edge.
REQ-006 done_in  input  1  completion of the channel currently in service.
REQ-007 req_valid_out  output  1  dispatch request to consumer.
REQ-008 req_ch_out  output  CH_W  channel index of request/service; stable while req_valid_out or active_out is high.
REQ-009 req_ready_in  input  1  consumer accepts dispatch.
REQ-010 active_out  output  1  a channel is in service (SERVE state).
REQ-011 busy_out  output  NUM_CH  per channel: pending OR in service.
REQ-012 timeout_out  output  NUM_CH  sticky per-channel timeout flag.
REQ-013 err_clr_in  input  NUM_CH  per-channel clear of timeout_out.

Function
REQ-014 Per-channel pending bit shall set on the edge where set_in[i]=1; repeated sets while pending coalesce (no count).
REQ-015 FSM shall have states IDLE, REQ, SERVE.
REQ-016 IDLE: if any pending bit, select channel round-robin starting at pointer rr_ptr, latch it into req_ch_out, go REQ next edge; else stay.
REQ-017 REQ: req_valid_out=1; on edge with req_ready_in=1 clear pending[req_ch_out] and go SERVE; req_valid_out shall not drop before acceptance.
REQ-018 SERVE: active_out=1; on edge with done_in=1 go IDLE and set rr_ptr = (req_ch_out+1) mod NUM_CH.
REQ-019 done_in outside SERVE shall be ignored.
REQ-020 set_in on the in-service channel during REQ or SERVE shall set its pending bit; done_in and set_in to that channel in the same cycle: service completes and channel stays pending.
REQ-021 Latency: set_in sampled at edge N -> busy_out high after edge N; req_valid_out high after edge N+1 when FSM was IDLE.
REQ-022 busy_out[i] shall deassert after the done_in edge unless re-pended.
REQ-023 Minimum ring-to-ring turnaround: one IDLE cycle between SERVE exit and next REQ.
REQ-024 rr_ptr wraps from NUM_CH-1 to 0; all-channels-pending shall be served in strict rotation.

Reset
REQ-025 rst high shall immediately force: state IDLE, pending all 0, rr_ptr 0, req_ch_out 0, req_valid_out 0, active_out 0, busy_out 0, timeout_out 0, timeout counter 0.
REQ-026 Reset mid-REQ or mid-SERVE shall abandon the transaction with no completion and no flag.
REQ-027 First arbitration after reset deassertion shall occur no earlier than the first edge with rst low.

Configuration
REQ-028 Macro DOORBELL_ARRAY_TIMEOUT_EN defined: a CNT_W counter clears on SERVE entry and increments each SERVE cycle; when it reaches TIMEOUT_CYC without done_in, FSM shall go IDLE, set timeout_out[req_ch_out], advance rr_ptr as for done.
REQ-029 done_in on the same edge as the timeout shall win (no flag).
REQ-030 err_clr_in[i] clears timeout_out[i] next edge; simultaneous set and clear: set wins.
REQ-031 Macro undefined: no counter, SERVE waits indefinitely, timeout_out tied 0, err_clr_in ignored.

Verification (NUM_CH=4, TIMEOUT_CYC=8, req_ready_in=1 unless stated)
REQ-032 Single ring: set_in=4'b0010 one cycle -> busy_out=4'b0010 next cycle, req_valid_out with req_ch_out=1 following cycle, active_out high, done_in pulse -> busy_out=0.
REQ-033 Round robin: set_in=4'b1111 one cycle, done_in two cycles after each dispatch -> service order 0,1,2,3; then set_in=4'b0011 -> order 0,1.
REQ-034 Backpressure: req_ready_in=0 for 5 cycles -> req_valid_out and req_ch_out held constant, active_out low until acceptance.
REQ-035 Coalesce/re-pend: set_in[2] three times while pending -> one dispatch; set_in[2] during SERVE of ch2 -> second dispatch of ch2 after done.
REQ-036 Timeout (macro on): no done_in -> after 8 SERVE cycles active_out low, timeout_out=4'b0001, next channel dispatched; err_clr_in[0] -> timeout_out=0; done_in on cycle 8 -> no flag.
REQ-037 Reset mid-SERVE: rst pulse with ch3 active and ch1 pending -> all outputs 0 immediately, no dispatch until new set_in.
